// File: rtl/nrisc_mem_pkg.sv
// Shared constants and helpers for the NRISC cluster data memory.
// Default geometry of the shared data memory and a width helper.
package nrisc_mem_pkg;

  localparam int NCORES_DEF = 2;
  localparam int LMEM_DEF   = 8;
  localparam int TAM_DEF    = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/data_mem_rr_arbiter.sv
// Combinational request arbiter for the shared data memory.
// Round-robin from last_grant+1, or fixed lowest-index priority.
module rr_arbiter
  import nrisc_mem_pkg::*;
#(
  parameter int N     = NCORES_DEF,
  parameter bit RR_EN = 1'b1,
  localparam int LGW  = (clog2(N) > 0) ? clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [LGW-1:0] last_grant,
  output logic [N-1:0]   grant,
  output logic           valid
);

  function automatic int pick(input int lg, input int s);
    if (RR_EN) return (lg + 1 + s) % N;
    return s;
  endfunction

  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int s = 0; s < N; s++) begin
      if (!valid && req[pick(int'(last_grant), s)]) begin
        grant[pick(int'(last_grant), s)] = 1'b1;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_mem_rr.sv
// Shared single-ported data memory for the NRISC cluster.
// Cores arbitrate per edge; winner gets a registered ack and data.
module data_mem_rr
  import nrisc_mem_pkg::*;
#(
  parameter int Ncores = NCORES_DEF,
  parameter int Lmem   = LMEM_DEF,
  parameter int TAM    = TAM_DEF,
  parameter bit RR_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [Ncores*TAM-1:0] dataIN,
  input  logic [Ncores*TAM-1:0] dataADDR,
  input  logic [Ncores-1:0]     dataWrite,
  input  logic [Ncores-1:0]     dataLoad,
  output logic [Ncores*TAM-1:0] dataOUT,
  output logic [Ncores-1:0]     dataAck
);

  localparam int LGW   = (clog2(Ncores) > 0) ? clog2(Ncores) : 1;
  localparam int DEPTH = 1 << Lmem;

  logic [TAM-1:0]        mem_q [DEPTH];
  logic [Ncores*TAM-1:0] out_q, out_d;
  logic [Ncores-1:0]     ack_q, ack_d;
  logic [LGW-1:0]        lg_q, lg_d;

  logic [Ncores-1:0] req_eff, grant;
  logic              gvalid;
  logic [LGW-1:0]    g_idx;
  logic              g_wr;
  logic [Lmem-1:0]   g_addr;
  logic [TAM-1:0]    g_wdata, rdata;
  logic              mem_we;

  // A core that was just acked may still be dropping its request.
  assign req_eff = (dataWrite | dataLoad) & ~ack_q;

  rr_arbiter #(
    .N     (Ncores),
    .RR_EN (RR_EN)
  ) u_arb (
    .req        (req_eff),
    .last_grant (lg_q),
    .grant      (grant),
    .valid      (gvalid)
  );

  always_comb begin
    g_idx = '0;
    for (int k = 0; k < Ncores; k++)
      if (grant[k]) g_idx = LGW'(k);
  end

  always_comb begin
    g_wr    = dataWrite[g_idx];
    g_addr  = dataADDR[g_idx*TAM +: Lmem];
    g_wdata = dataIN[g_idx*TAM +: TAM];
    rdata   = mem_q[g_addr];
    mem_we  = gvalid & g_wr;
  end

  always_comb begin
    out_d = out_q;
    ack_d = grant;
    lg_d  = lg_q;
    if (gvalid) begin
      out_d[g_idx*TAM +: TAM] = g_wr ? g_wdata : rdata;
      lg_d = g_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      ack_q <= '0;
      lg_q  <= LGW'(Ncores - 1);
    end else begin
      out_q <= out_d;
      ack_q <= ack_d;
      lg_q  <= lg_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[g_addr] <= g_wdata;
    end
  end

  assign dataOUT = out_q;
  assign dataAck = ack_q;

endmodule

// File: tb/tb_data_mem_rr.sv
// Bench for data_mem_rr: directed scenarios plus random traffic.
// Instance 0 is round-robin, instance 1 fixed priority.
module tb_data_mem_rr;

  localparam int N = 2;
  localparam int L = 8;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  logic [N*W-1:0] din [2];
  logic [N*W-1:0] adr [2];
  logic [N*W-1:0] dout [2];
  logic [N-1:0]   wr [2];
  logic [N-1:0]   ld [2];
  logic [N-1:0]   ack [2];

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_mem [2][256];
  logic [W-1:0] m_out [2][N];
  logic         m_ack [2][N];
  int           m_last [2];

  always #5 clk = ~clk;

  data_mem_rr #(.Ncores(N), .Lmem(L), .TAM(W), .RR_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .dataIN    (din[0]),
    .dataADDR  (adr[0]),
    .dataWrite (wr[0]),
    .dataLoad  (ld[0]),
    .dataOUT   (dout[0]),
    .dataAck   (ack[0])
  );

  data_mem_rr #(.Ncores(N), .Lmem(L), .TAM(W), .RR_EN(1'b0)) dut_fp (
    .clk       (clk),
    .rst       (rst),
    .dataIN    (din[1]),
    .dataADDR  (adr[1]),
    .dataWrite (wr[1]),
    .dataLoad  (ld[1]),
    .dataOUT   (dout[1]),
    .dataAck   (ack[1])
  );

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: service rules applied to whole transactions per edge.
  task automatic model_edge();
    int g;
    int c;
    logic [7:0] a;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int j = 0; j < 256; j++) m_mem[i][j] = '0;
        for (int k = 0; k < N; k++) begin
          m_out[i][k] = '0;
          m_ack[i][k] = 1'b0;
        end
        m_last[i] = N - 1;
      end else begin
        g = -1;
        for (int s = 0; s < N; s++) begin
          c = (i == 0) ? (m_last[i] + 1 + s) % N : s;
          if (g < 0 && (wr[i][c] || ld[i][c]) && !m_ack[i][c]) g = c;
        end
        for (int k = 0; k < N; k++) m_ack[i][k] = 1'b0;
        if (g >= 0) begin
          a = adr[i][g*W +: 8];
          if (wr[i][g]) begin
            m_mem[i][a] = din[i][g*W +: W];
            m_out[i][g] = din[i][g*W +: W];
          end else begin
            m_out[i][g] = m_mem[i][a];
          end
          m_ack[i][g] = 1'b1;
          m_last[i] = g;
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < N; k++) begin
        chk($sformatf("i%0d ack%0d", i, k), W'(ack[i][k]), W'(m_ack[i][k]));
        chk($sformatf("i%0d out%0d", i, k), dout[i][k*W +: W], m_out[i][k]);
      end
  endtask

  task automatic set_req(input int i, input int k, input bit w,
                         input bit l, input logic [W-1:0] a,
                         input logic [W-1:0] d);
    wr[i][k] = w;
    ld[i][k] = l;
    adr[i][k*W +: W] = a;
    din[i][k*W +: W] = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++) begin
      wr[i] = '0;
      ld[i] = '0;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      din[i] = '0;
      adr[i] = '0;
    end
    idle_all();
    rst = 1'b1;
    #1;
    tick();
    chk("reset ack", W'(ack[0]), '0);
    chk("reset out0", dout[0][0 +: W], '0);
    rst = 1'b0;

    // read after reset
    set_req(0, 0, 0, 1, 16'h0005, 16'h0);
    tick();
    chk("s1 ack0", W'(ack[0][0]), 16'h1);
    chk("s1 ack1", W'(ack[0][1]), 16'h0);
    chk("s1 out0", dout[0][0 +: W], 16'h0000);
    idle_all();
    tick();

    // write then read back
    set_req(0, 0, 1, 0, 16'h0010, 16'h1234);
    tick();
    chk("s2 echo", dout[0][0 +: W], 16'h1234);
    chk("s2 ack", W'(ack[0][0]), 16'h1);
    idle_all();
    tick();
    set_req(0, 0, 0, 1, 16'h0010, 16'h0);
    tick();
    chk("s2 read", dout[0][0 +: W], 16'h1234);
    idle_all();
    tick();

    // simultaneous writes to one address from reset
    rst = 1'b1;
    set_req(0, 0, 1, 0, 16'h0020, 16'hAAAA);
    set_req(0, 1, 1, 0, 16'h0020, 16'h5555);
    tick();
    chk("s3 rst ack", W'(ack[0]), '0);
    rst = 1'b0;
    tick();
    chk("s3 c1 ack", W'(ack[0]), 16'h1);
    set_req(0, 0, 0, 0, 16'h0020, 16'h0);
    tick();
    chk("s3 c2 ack", W'(ack[0]), 16'h2);
    idle_all();
    set_req(0, 0, 0, 1, 16'h0020, 16'h0);
    tick();
    chk("s3 read", dout[0][0 +: W], 16'h5555);
    idle_all();
    tick();

    // sustained contention
    set_req(0, 0, 0, 1, 16'h0010, 16'h0);
    set_req(0, 1, 0, 1, 16'h0020, 16'h0);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("s4 one ack", W'(ack[0][0] ^ ack[0][1]), 16'h1);
    end
    idle_all();
    tick();

    // aliasing through ignored high address bits
    set_req(0, 1, 1, 0, 16'h01FF, 16'hBEEF);
    tick();
    idle_all();
    tick();
    set_req(0, 0, 0, 1, 16'h00FF, 16'h0);
    tick();
    chk("s5 alias", dout[0][0 +: W], 16'hBEEF);
    idle_all();
    tick();

    // reset at the same edge as a write
    rst = 1'b1;
    set_req(0, 0, 1, 0, 16'h0030, 16'h7777);
    tick();
    chk("s6 rst ack", W'(ack[0][0]), 16'h0);
    chk("s6 rst out", dout[0][0 +: W], 16'h0000);
    rst = 1'b0;
    tick();
    chk("s6 held ack", W'(ack[0][0]), 16'h1);
    chk("s6 held echo", dout[0][0 +: W], 16'h7777);
    idle_all();
    set_req(0, 0, 0, 1, 16'h0030, 16'h0);
    tick();
    chk("s6 read", dout[0][0 +: W], 16'h7777);
    idle_all();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 0, 0, 1, 16'h0030, 16'h0);
    tick();
    chk("s6 cleared", dout[0][0 +: W], 16'h0000);
    idle_all();
    tick();

    // fixed priority: core0 first even after it was last served
    set_req(1, 0, 1, 0, 16'h0040, 16'h1111);
    tick();
    idle_all();
    tick();
    set_req(1, 0, 0, 1, 16'h0040, 16'h0);
    set_req(1, 1, 0, 1, 16'h0040, 16'h0);
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("fp ack0", W'(ack[1][0]), W'((c % 2) == 0));
    end
    idle_all();
    tick();

    // random traffic, requests held until acked
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < N; k++) begin
          if (m_ack[i][k]) begin
            wr[i][k] = 1'b0;
            ld[i][k] = 1'b0;
          end else if (!(wr[i][k] || ld[i][k]) && $urandom_range(0, 2) == 0) begin
            logic w;
            w = 1'($urandom_range(0, 1));
            set_req(i, k, w, w ? 1'($urandom_range(0, 1)) : 1'b1,
                    {W'($urandom_range(0, 255)) << 8} | W'($urandom_range(0, 15)),
                    W'($urandom));
          end
        end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
